lpf_cascade: RTL and testbench

// - Pipelined cascade of NUM_STAGES single-pole IIR low-pass stages; each stage is individually enabled or bypassed.
// - Sits downstream of the sine/cosine mixer in the lock-in amplifier.
// - One instance each filters the sin product, cos product, raw ADC input and DC path.
// - Output feeds real_comp/imag_comp.

---
 rtl/lpf_cascade_if.sv | 24 ++
 rtl/lpf_cascade.sv | 89 ++++++++
 tb/tb_lpf_cascade.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpf_cascade_if.sv
// Sample stream bundle for lpf_cascade: qualified input and output samples.
`timescale 1ns/1ps
interface lpf_cascade_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/lpf_cascade.sv
// Pipelined cascade of single-pole IIR low-pass stages, each one bypassable.
// Define LPF_ROUND_EN for round-half-up stage outputs with positive saturation.
`timescale 1ns/1ps
module lpf_cascade #(
    parameter int DATA_W     = 16,
    parameter int NUM_STAGES = 10,
    parameter int MAX_SHIFT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] enable,
    input  logic [3:0]            shift,
    lpf_cascade_if.slave          bus
);
    localparam int FRAC = MAX_SHIFT;
    localparam int W    = DATA_W + FRAC;
    localparam logic [3:0] SH_MAX = 4'(MAX_SHIFT);

    logic signed [W-1:0]      s_q [NUM_STAGES];
    logic signed [W-1:0]      s_d [NUM_STAGES];
    logic [NUM_STAGES-1:0]    v_q;
    logic [NUM_STAGES-1:0]    v_d;
    logic signed [DATA_W-1:0] y   [NUM_STAGES];
    logic [3:0]               sh;

    assign sh = (int'(shift) > MAX_SHIFT) ? SH_MAX : shift;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic signed [DATA_W-1:0] x_in;
        logic                     v_in;
        logic signed [W-1:0]      xe;
        logic signed [W:0]        diff;
        logic signed [W:0]        step;
        logic signed [W:0]        sum;
        logic                     unused_msb;

        if (k == 0) begin : g_head
            assign x_in = bus.in_data;
            assign v_in = bus.in_valid;
        end else begin : g_tail
            assign x_in = y[k-1];
            assign v_in = v_q[k-1];
        end

        // Difference needs one extra bit; the convex update always fits W.
        assign xe   = {x_in, {FRAC{1'b0}}};
        assign diff = {xe[W-1], xe} - {s_q[k][W-1], s_q[k]};
        assign step = diff >>> sh;
        assign sum  = {s_q[k][W-1], s_q[k]} + step;
        assign unused_msb = sum[W];

        assign s_d[k] = !v_in     ? s_q[k]
                      : enable[k] ? sum[W-1:0]
                      :             xe;
        assign v_d[k] = v_in;

`ifdef LPF_ROUND_EN
        localparam logic [W:0] HALF = (W+1)'(2**(FRAC-1));
        logic [W:0] rnd;
        logic       unused_rnd;

        assign rnd        = {s_q[k][W-1], s_q[k]} + HALF;
        assign unused_rnd = ^rnd[FRAC-1:0];
        // Only a positive state can carry past the top bit when rounding.
        assign y[k] = (rnd[W] != rnd[W-1])
                    ? {1'b0, {(DATA_W-1){1'b1}}}
                    : rnd[W-1:FRAC];
`else
        assign y[k] = s_q[k][W-1:FRAC];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                s_q[k] <= '0;
            end
            v_q <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                s_q[k] <= s_d[k];
            end
            v_q <= v_d;
        end
    end

    assign bus.out_data  = y[NUM_STAGES-1];
    assign bus.out_valid = v_q[NUM_STAGES-1];
endmodule

// File: tb/tb_lpf_cascade.sv
// Directed bench for lpf_cascade: 10-stage, 1-stage and clamped 1-stage copies.
`timescale 1ns/1ps
module tb_lpf_cascade;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] en_a;
    logic [3:0] sh_a;
    logic [0:0] en_b;
    logic [3:0] sh_b;
    logic [0:0] en_c;
    logic [3:0] sh_c;

    int n_chk  = 0;
    int n_fail = 0;

    int exp_pos [4];
    int exp_neg [2];
    int exp_gap [4];
    int pat_gap [4];
    int exp_ext_p;
    int exp_clp;

    lpf_cascade_if #(.DATA_W(16)) if_a ();
    lpf_cascade_if #(.DATA_W(16)) if_b ();
    lpf_cascade_if #(.DATA_W(16)) if_c ();

    lpf_cascade #(.DATA_W(16), .NUM_STAGES(10), .MAX_SHIFT(15)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .enable (en_a),
        .shift  (sh_a),
        .bus    (if_a)
    );

    lpf_cascade #(.DATA_W(16), .NUM_STAGES(1), .MAX_SHIFT(15)) u_one (
        .clk    (clk),
        .rst    (rst),
        .enable (en_b),
        .shift  (sh_b),
        .bus    (if_b)
    );

    lpf_cascade #(.DATA_W(16), .NUM_STAGES(1), .MAX_SHIFT(4)) u_clp (
        .clk    (clk),
        .rst    (rst),
        .enable (en_c),
        .shift  (sh_c),
        .bus    (if_c)
    );

    always #2 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_a.in_valid = 1'b0;
        if_b.in_valid = 1'b0;
        if_c.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef LPF_ROUND_EN
        exp_pos   = '{250, 438, 578, 684};
        exp_neg   = '{-250, -437};
        exp_gap   = '{250, 250, 250, 438};
        exp_ext_p = 32767;
        exp_clp   = 194;
`else
        exp_pos   = '{250, 437, 578, 683};
        exp_neg   = '{-250, -438};
        exp_gap   = '{250, 250, 250, 437};
        exp_ext_p = 32766;
        exp_clp   = 193;
`endif
        pat_gap = '{1, 0, 0, 1};

        // reset held with valid input present
        rst  = 1'b1;
        en_a = '0;
        sh_a = 4'd0;
        en_b = 1'b1;
        sh_b = 4'd2;
        en_c = 1'b1;
        sh_c = 4'd15;
        if_a.in_valid = 1'b1;
        if_a.in_data  = 16'sd1234;
        if_b.in_valid = 1'b1;
        if_b.in_data  = 16'sd1234;
        if_c.in_valid = 1'b1;
        if_c.in_data  = 16'sd1234;
        repeat (3) begin
            tick();
            check("rst_valid", int'(if_a.out_valid), 0);
            check("rst_data", int'($signed(if_a.out_data)), 0);
        end
        rst = 1'b0;
        idle_all();
        repeat (10) begin
            tick();
            check("post_rst_valid", int'(if_a.out_valid), 0);
        end

        // bypass ramp: latency exactly 10
        en_a = '0;
        for (int t = 0; t < 110; t++) begin
            if (t >= 10) begin
                check("byp_valid", int'(if_a.out_valid), 1);
                check("byp_data", int'($signed(if_a.out_data)), t - 10);
            end else begin
                check("byp_lead", int'(if_a.out_valid), 0);
            end
            if_a.in_valid = (t < 100);
            if_a.in_data  = 16'(t);
            tick();
        end

        // only stage 0 filtering inside the 10-stage cascade
        do_reset();
        en_a = 10'b1;
        sh_a = 4'd2;
        for (int t = 0; t < 13; t++) begin
            if (t == 10 || t == 11) begin
                check("part_valid", int'(if_a.out_valid), 1);
                check("part_data", int'($signed(if_a.out_data)),
                      exp_pos[t-10]);
            end
            if (t == 12) begin
                check("part_end", int'(if_a.out_valid), 0);
            end
            if_a.in_valid = (t < 2);
            if_a.in_data  = 16'sd1000;
            tick();
        end
        idle_all();

        // single stage positive step
        do_reset();
        en_b = 1'b1;
        sh_b = 4'd2;
        for (int t = 0; t < 5; t++) begin
            if (t > 0) begin
                check("step_valid", int'(if_b.out_valid), 1);
                check("step_data", int'($signed(if_b.out_data)),
                      exp_pos[t-1]);
            end
            if_b.in_valid = (t < 4);
            if_b.in_data  = 16'sd1000;
            tick();
        end

        // single stage negative step
        do_reset();
        for (int t = 0; t < 3; t++) begin
            if (t > 0) begin
                check("neg_data", int'($signed(if_b.out_data)),
                      exp_neg[t-1]);
            end
            if_b.in_valid = (t < 2);
            if_b.in_data  = -16'sd1000;
            tick();
        end

        // valid gaps hold state and propagate
        do_reset();
        for (int t = 0; t < 5; t++) begin
            if (t > 0) begin
                check("gap_valid", int'(if_b.out_valid), pat_gap[t-1]);
                check("gap_data", int'($signed(if_b.out_data)),
                      exp_gap[t-1]);
            end
            if_b.in_valid = (t < 4) ? pat_gap[t % 4][0] : 1'b0;
            if_b.in_data  = 16'sd1000;
            tick();
        end

        // shift 0 behaves as bypass
        sh_b = 4'd0;
        if_b.in_valid = 1'b1;
        if_b.in_data  = 16'sd777;
        tick();
        idle_all();
        check("sh0_valid", int'(if_b.out_valid), 1);
        check("sh0_data", int'($signed(if_b.out_data)), 777);

        // full-scale: precharge at +max, then one -min sample at shift 15
        do_reset();
        en_a = '1;
        sh_a = 4'd0;
        for (int t = 0; t < 21; t++) begin
            if (t == 19) begin
                check("ext_pre_p", int'($signed(if_a.out_data)), 32767);
            end
            if (t == 20) begin
                check("ext_valid_p", int'(if_a.out_valid), 1);
                check("ext_data_p", int'($signed(if_a.out_data)), exp_ext_p);
            end
            if (t == 10) begin
                sh_a = 4'd15;
            end
            if_a.in_valid = (t <= 10);
            if_a.in_data  = (t < 10) ? 16'sh7fff : 16'sh8000;
            tick();
        end

        do_reset();
        sh_a = 4'd0;
        for (int t = 0; t < 21; t++) begin
            if (t == 19) begin
                check("ext_pre_n", int'($signed(if_a.out_data)), -32768);
            end
            if (t == 20) begin
                check("ext_data_n", int'($signed(if_a.out_data)), -32768);
            end
            if (t == 10) begin
                sh_a = 4'd15;
            end
            if_a.in_valid = (t <= 10);
            if_a.in_data  = (t < 10) ? 16'sh8000 : 16'sh7fff;
            tick();
        end

        // mid-stream reset flushes the pipeline
        do_reset();
        en_a = '0;
        sh_a = 4'd0;
        for (int t = 0; t < 18; t++) begin
            if (t >= 6 && t < 16) begin
                check("flush_valid", int'(if_a.out_valid), 0);
            end
            if (t == 16) begin
                check("flush_first_v", int'(if_a.out_valid), 1);
                check("flush_first", int'($signed(if_a.out_data)), 500);
            end
            if (t == 17) begin
                check("flush_second", int'($signed(if_a.out_data)), 501);
            end
            rst           = (t == 5);
            if_a.in_valid = 1'b1;
            if_a.in_data  = (t < 5) ? 16'(100 + t)
                          : (t == 5) ? 16'sd999 : 16'(500 + t - 6);
            tick();
        end
        rst = 1'b0;
        idle_all();

        // shift 15 clamps to MAX_SHIFT=4
        do_reset();
        en_c = 1'b1;
        sh_c = 4'd15;
        for (int t = 0; t < 3; t++) begin
            if (t == 1) begin
                check("clamp_1", int'($signed(if_c.out_data)), 100);
            end
            if (t == 2) begin
                check("clamp_2", int'($signed(if_c.out_data)), exp_clp);
            end
            if_c.in_valid = (t < 2);
            if_c.in_data  = 16'sd1600;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
